alu_seq: RTL and testbench

Parametrised, handshaked, multi-cycle successor to the 4-bit combinational ALU. It accepts one operation per transaction on a valid/ready input, then computes it. Logic, add/sub and compare ops take one cycle. Shifts iterate one bit per cycle, and multiply runs a WIDTH-cycle shift-add. Results and flags are held registered until the consumer takes them. It sits between the NPC decode/issue stage and writeback.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_core.sv | 51 +++++
 rtl/alu_seq.sv | 166 ++++++++++++++++
 tb/tb_alu_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state types for the sequential ALU and its combinational core.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_NOT  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_EQ   = 4'd7,
        OP_SLTU = 4'd8,
        OP_SLL  = 4'd9,
        OP_SRL  = 4'd10,
        OP_SRA  = 4'd11,
        OP_MUL  = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ops that iterate in BUSY rather than completing in the accept cycle.
    function automatic logic is_multi(op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle ALU datapath: logic, add/sub, compares, and illegal-op decode.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             car,
    output logic             of,
    output logic             err
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // Carry out of a + ~b + 1 is the "no borrow" flag.
    assign diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

    always_comb begin
        res = '0;
        car = 1'b0;
        of  = 1'b0;
        err = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                {car, res} = sum;
                of = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                {car, res} = diff;
                of = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_NOT:  res = ~a;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_EQ:   res = {{(WIDTH-1){1'b0}}, a == b};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL, OP_SRL, OP_SRA, OP_MUL: res = '0;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle ops via alu_core, bit-serial shifts, shift-add multiply.
// Result is held in DONE until out_ready; in_ready is high only in IDLE.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             car,
    output logic             of,
    output logic             zero,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             car_q, car_d;
    logic             of_q, of_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] core_res;
    logic             core_car, core_of, core_err;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] sh_step;
    logic [WIDTH-1:0] acc_nx;
    op_e              op_in;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op  (op),
        .a   (a),
        .b   (b),
        .res (core_res),
        .car (core_car),
        .of  (core_of),
        .err (core_err)
    );

    assign op_in  = op_e'(op);
    assign sh_amt = b[SHW-1:0];
    assign acc_nx = opb_q[0] ? (acc_q + opa_q) : acc_q;

    always_comb begin
        sh_step = opa_q;
        case (op_q)
            OP_SLL:  sh_step = {opa_q[WIDTH-2:0], 1'b0};
            OP_SRL:  sh_step = {1'b0, opa_q[WIDTH-1:1]};
            OP_SRA:  sh_step = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
            default: sh_step = opa_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        car_d   = car_q;
        of_d    = of_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = op_in;
                    opa_d = a;
                    opb_d = b;
                    if (!is_multi(op_in)) begin
                        res_d   = core_res;
                        car_d   = core_car;
                        of_d    = core_of;
                        err_d   = core_err;
                        state_d = DONE;
                    end else begin
                        car_d = 1'b0;
                        of_d  = 1'b0;
                        err_d = 1'b0;
                        if (op_in == OP_MUL) begin
                            acc_d   = '0;
                            cnt_d   = CW'(WIDTH);
                            state_d = BUSY;
                        end else if (sh_amt == '0) begin
                            res_d   = a;
                            state_d = DONE;
                        end else begin
                            cnt_d   = {1'b0, sh_amt};
                            state_d = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    acc_d = acc_nx;
                    opa_d = {opa_q[WIDTH-2:0], 1'b0};
                    opb_d = {1'b0, opb_q[WIDTH-1:1]};
                end else begin
                    opa_d = sh_step;
                end
                // Last iteration writes the result directly so DONE follows with no extra cycle.
                if (cnt_q == CW'(1)) begin
                    res_d   = (op_q == OP_MUL) ? acc_nx : sh_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            car_q   <= 1'b0;
            of_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            car_q   <= car_d;
            of_q    <= of_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res       = res_q;
    assign car       = car_q;
    assign of        = of_q;
    assign err       = err_q;
    assign zero      = (res_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: hand-computed results, flags and latencies.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res;
    logic         car, of, zero, err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .car       (car),
        .of        (of),
        .zero      (zero),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one op; returns at the negedge after the accept edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op = o;
        a  = va;
        b  = vb;
        @(negedge clk);
        in_valid = 1'b0;
        op = 4'd0;
        a  = '0;
        b  = '0;
    endtask

    // Cycles counted so that a result registered on the accept edge reads as latency 1.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_consume", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [3:0] o, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [W-1:0] e_res, input logic e_car,
                       input logic e_of, input logic e_err, input int e_lat);
        int lat;
        issue(o, va, vb);
        wait_valid(lat);
        chk({tag, "_lat"}, lat, e_lat);
        chk({tag, "_res"}, {24'd0, res}, {24'd0, e_res});
        chk({tag, "_car"}, {31'd0, car}, {31'd0, e_car});
        chk({tag, "_of"},  {31'd0, of},  {31'd0, e_of});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (e_res == '0)});
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        consume();
    endtask

    initial begin
        int lat;
        logic [W-1:0] held_res;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_res",       {24'd0, res},       32'd0);
        chk("rst_car",       {31'd0, car},       32'd0);
        chk("rst_of",        {31'd0, of},        32'd0);
        chk("rst_err",       {31'd0, err},       32'd0);
        chk("rst_zero",      {31'd0, zero},      32'd1);

        //   tag        op     a      b      res    car   of    err   lat
        run("add_of",   4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1);
        run("add_car",  4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1);
        run("sub_of",   4'd1,  8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1);
        run("not",      4'd2,  8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 1);
        run("and",      4'd3,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1);
        run("or",       4'd4,  8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1);
        run("slt",      4'd6,  8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1);
        run("eq",       4'd7,  8'h3C, 8'h3C, 8'h01, 1'b0, 1'b0, 1'b0, 1);
        run("sltu",     4'd8,  8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        run("sra3",     4'd11, 8'h90, 8'h03, 8'hF2, 1'b0, 1'b0, 1'b0, 4);
        run("srl4",     4'd10, 8'h90, 8'hF4, 8'h09, 1'b0, 1'b0, 1'b0, 5);
        run("sll1",     4'd9,  8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 2);
        run("sll0",     4'd9,  8'h5A, 8'h08, 8'h5A, 1'b0, 1'b0, 1'b0, 1);
        run("mul",      4'd12, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 1'b0, 9);
        run("mul_ff",   4'd12, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 9);
        run("illegal",  4'd14, 8'h55, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1, 1);

        // Backpressure: hold result with out_ready low while new ops are offered.
        issue(4'd5, 8'hF0, 8'h3C);
        wait_valid(lat);
        chk("bp_lat", lat, 1);
        held_res = res;
        chk("bp_res", {24'd0, held_res}, 32'h0000_00CC);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op = 4'd0;
            a  = 8'h11;
            b  = 8'h22;
            @(negedge clk);
            chk("bp_hold_valid",  {31'd0, out_valid}, 32'd1);
            chk("bp_hold_res",    {24'd0, res},       32'h0000_00CC);
            chk("bp_hold_ready",  {31'd0, in_ready},  32'd0);
            chk("bp_hold_zero",   {31'd0, zero},      32'd0);
        end
        in_valid = 1'b0;
        consume();
        chk("bp_ready_after", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a multiply.
        issue(4'd12, 8'h03, 8'h05);
        repeat (3) @(negedge clk);
        chk("midrst_busy_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_res",       {24'd0, res},       32'd0);
        chk("midrst_zero",      {31'd0, zero},      32'd1);
        repeat (10) @(negedge clk);
        chk("midrst_no_late_valid", {31'd0, out_valid}, 32'd0);
        run("add_after_rst", 4'd0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
